// File: rtl/sd_pkg.sv
// Constants, state encoding and CRC7 step shared by the SD CMD line engine.
package sd_pkg;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_48   = 2'd1;
   localparam logic [1:0] RESP_136  = 2'd2;

   localparam int CMD_FRAME_LEN = 48;
   localparam int RESP_LONG_LEN = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SEND      = 3'd1;
   localparam logic [2:0] ST_WAIT_RESP = 3'd2;
   localparam logic [2:0] ST_READ_RESP = 3'd3;
   localparam logic [2:0] ST_CHECK     = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;

   // One MSB-first step of x^7+x^3+1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 accumulator; clear takes priority over enable.
module sd_crc7_serial
   import sd_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (enable_i) begin
         crc_d = crc7_step(crc_q, bit_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_controller.sv
// SD CMD line engine (1-bit mode): sends a 48-bit command with CRC7, optionally
// receives and checks a 48/136-bit response, then holds the line high for Ncc.
//
// state      | meaning
// IDLE       | line driven high, ready, waiting for start
// SEND       | shifting out the 48-bit command frame
// WAIT_RESP  | line released, waiting for response start bit (Ncr)
// READ_RESP  | shifting in the response
// CHECK      | one cycle: framing/CRC/index check, publish response
// GAP        | line driven high for NCC_CYCLES
module sd_cmd_controller
   import sd_pkg::*;
#(
   parameter int TIMEOUT    = 64,
   parameter int NCC_CYCLES = 8
) (
   input  logic         sdClock_i,
   input  logic         reset_i,
   inout  wire          sdCmd_io,
   input  logic         start_i,
   input  logic [5:0]   cmdIndex_i,
   input  logic [31:0]  cmdArgument_i,
   input  logic [1:0]   responseType_i,
   input  logic         checkCrc_i,
   output logic         ready_o,
   output logic [127:0] response_o,
   output logic         finished_o,
   output logic         error_o,
   output logic         timeout_o
);

   logic [2:0]   state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [39:0]  tx_sr_q, tx_sr_d;
   logic [134:0] rx_sr_q, rx_sr_d;
   logic [5:0]   idx_q, idx_d;
   logic [1:0]   rtype_q, rtype_d;
   logic         chk_q, chk_d;
   logic [127:0] resp_q, resp_d;
   logic         fin_q, fin_d;
   logic         err_q, err_d;
   logic         to_q, to_d;

   logic         crc_clear, crc_en, crc_bit;
   logic [6:0]   crc;
   logic         cmd_oe, cmd_out, cmd_in;
   logic         is_long;
   logic [7:0]   rx_len;
   logic         rx_err;

   // TX and RX never overlap, so one accumulator serves both directions.
   sd_crc7_serial u_crc (
      .clk_i    (sdClock_i),
      .reset_i  (reset_i),
      .clear_i  (crc_clear),
      .enable_i (crc_en),
      .bit_i    (crc_bit),
      .crc_o    (crc)
   );

   assign is_long = (rtype_q == RESP_136);
   assign rx_len  = is_long ? 8'(RESP_LONG_LEN) : 8'(CMD_FRAME_LEN);

   always_comb begin
      cmd_oe  = 1'b1;
      cmd_out = 1'b1;
      case (state_q)
         ST_SEND: begin
            if (cnt_q < 8'd40) begin
               cmd_out = tx_sr_q[39];
            end else if (cnt_q < 8'd47) begin
               cmd_out = crc[3'(8'd46 - cnt_q)];
            end
         end
         ST_WAIT_RESP, ST_READ_RESP, ST_CHECK: cmd_oe = 1'b0;
         default: cmd_out = 1'b1;
      endcase
   end

   assign sdCmd_io = cmd_oe ? cmd_out : 1'bz;
   assign cmd_in   = sdCmd_io;

   always_comb begin
      if (is_long) begin
         rx_err = rx_sr_q[134] | ~rx_sr_q[0] | (chk_q & (rx_sr_q[7:1] != crc));
      end else begin
         rx_err = rx_sr_q[46] | ~rx_sr_q[0]
                | (chk_q & ((rx_sr_q[7:1] != crc) | (rx_sr_q[45:40] != idx_q)));
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      idx_d     = idx_q;
      rtype_d   = rtype_q;
      chk_d     = chk_q;
      resp_d    = resp_q;
      fin_d     = 1'b0;
      err_d     = err_q;
      to_d      = to_q;
      crc_clear = 1'b0;
      crc_en    = 1'b0;
      crc_bit   = cmd_in;
      case (state_q)
         ST_IDLE: begin
            crc_clear = 1'b1;
            if (start_i) begin
               state_d = ST_SEND;
               cnt_d   = '0;
               tx_sr_d = {1'b0, 1'b1, cmdIndex_i, cmdArgument_i};
               idx_d   = cmdIndex_i;
               rtype_d = (responseType_i == RESP_48 || responseType_i == RESP_136)
                         ? responseType_i : RESP_NONE;
               chk_d   = checkCrc_i;
               err_d   = 1'b0;
               to_d    = 1'b0;
            end
         end
         ST_SEND: begin
            crc_bit = tx_sr_q[39];
            crc_en  = (cnt_q < 8'd40);
            tx_sr_d = {tx_sr_q[38:0], 1'b0};
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'(CMD_FRAME_LEN - 1)) begin
               cnt_d     = '0;
               crc_clear = 1'b1;
               if (rtype_q == RESP_NONE) begin
                  state_d = ST_GAP;
                  fin_d   = 1'b1;
               end else begin
                  state_d = ST_WAIT_RESP;
               end
            end
         end
         ST_WAIT_RESP: begin
            cnt_d = cnt_q + 8'd1;
            if (!cmd_in) begin
               // The start bit is the first response bit; long responses skip it in the CRC.
               state_d = ST_READ_RESP;
               cnt_d   = 8'd1;
               rx_sr_d = '0;
               crc_en  = !is_long;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               fin_d   = 1'b1;
               err_d   = 1'b1;
               to_d    = 1'b1;
            end
         end
         ST_READ_RESP: begin
            rx_sr_d = {rx_sr_q[133:0], cmd_in};
            cnt_d   = cnt_q + 8'd1;
            crc_en  = (cnt_q <= rx_len - 8'd9) && (!is_long || cnt_q >= 8'd8);
            if (cnt_q == rx_len - 8'd1) begin
               state_d = ST_CHECK;
               cnt_d   = '0;
            end
         end
         ST_CHECK: begin
            state_d = ST_GAP;
            cnt_d   = '0;
            fin_d   = 1'b1;
            err_d   = rx_err;
            resp_d  = is_long ? {rx_sr_q[127:1], 1'b0} : {96'd0, rx_sr_q[39:8]};
         end
         ST_GAP: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(NCC_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge sdClock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tx_sr_q <= '0;
         rx_sr_q <= '0;
         idx_q   <= '0;
         rtype_q <= RESP_NONE;
         chk_q   <= 1'b0;
         resp_q  <= '0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_sr_q <= tx_sr_d;
         rx_sr_q <= rx_sr_d;
         idx_q   <= idx_d;
         rtype_q <= rtype_d;
         chk_q   <= chk_d;
         resp_q  <= resp_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign ready_o    = (state_q == ST_IDLE);
   assign response_o = resp_q;
   assign finished_o = fin_q;
   assign error_o    = err_q;
   assign timeout_o  = to_q;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Directed bench for sd_cmd_controller with a simple card model on the CMD line.
module tb_sd_cmd_controller;
   import sd_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [5:0]   cmd_index = '0;
   logic [31:0]  cmd_arg = '0;
   logic [1:0]   resp_type = '0;
   logic         check_crc = 1'b0;
   logic         ready, finished, error, timeout;
   logic [127:0] response;
   wire          sd_cmd;
   logic         tb_oe = 1'b0;
   logic         tb_bit = 1'b1;
   int           checks = 0;
   int           errors = 0;

   assign sd_cmd = tb_oe ? tb_bit : 1'bz;
   pullup (sd_cmd);

   always #5 clk = ~clk;

   sd_cmd_controller #(.TIMEOUT(64), .NCC_CYCLES(8)) dut (
      .sdClock_i      (clk),
      .reset_i        (rst),
      .sdCmd_io       (sd_cmd),
      .start_i        (start),
      .cmdIndex_i     (cmd_index),
      .cmdArgument_i  (cmd_arg),
      .responseType_i (resp_type),
      .checkCrc_i     (check_crc),
      .ready_o        (ready),
      .response_o     (response),
      .finished_o     (finished),
      .error_o        (error),
      .timeout_o      (timeout)
   );

   // Reference CRC7 by long division of msg*x^7 by 0x89.
   function automatic logic [6:0] crc7_ref(input logic [119:0] msg);
      logic [7:0] rem;
      logic       b;
      rem = 8'h00;
      for (int i = 119; i >= -7; i--) begin
         b = 1'b0;
         if (i >= 0) b = msg[i];
         rem = {rem[6:0], b};
         if (rem[7]) rem = rem ^ 8'h89;
      end
      return rem[6:0];
   endfunction

   // Ends at the negedge of cycle 1 (start sampled on the preceding posedge).
   task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [1:0] rt, input logic chk);
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; resp_type = rt; check_crc = chk; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Samples cycles 1..48; ends at the negedge of cycle 48.
   task automatic capture_tx(output logic [47:0] f);
      f = '0;
      for (int i = 0; i < 48; i++) begin
         if (i != 0) @(negedge clk);
         f = {f[46:0], sd_cmd};
      end
   endtask

   task automatic drive_reply(input logic [135:0] bits, input int n, input int delay,
                              input int pulse_at);
      repeat (delay) @(negedge clk);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         tb_oe = 1'b1; tb_bit = bits[i];
         start = (i == pulse_at);
      end
      @(negedge clk);
      tb_oe = 1'b0; start = 1'b0;
   endtask

   task automatic wait_fin(input int limit, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (finished !== 1'b1 && waited < limit);
   endtask

   task automatic wait_ready(input int limit);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
      checks++; if (sd_cmd !== 1'b1) begin errors++; $display("FAIL rst_cmd got %b want 1", sd_cmd); end
      checks++; if ({finished, error, timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {finished, error, timeout}); end
      checks++; if (response !== 128'd0) begin errors++; $display("FAIL rst_resp got %h want 0", response); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", ready); end
   endtask

   task automatic test_cmd0;
      logic [47:0] f;
      issue(6'd0, 32'h0, RESP_NONE, 1'b0);
      capture_tx(f);
      checks++; if (f !== 48'h40_0000_0000_95) begin errors++; $display("FAIL cmd0_frame got %h want 400000000095", f); end
      checks++; if (finished !== 1'b0) begin errors++; $display("FAIL cmd0_fin48 got %b want 0", finished); end
      @(negedge clk);
      checks++; if (finished !== 1'b1) begin errors++; $display("FAIL cmd0_fin49 got %b want 1", finished); end
      checks++; if (error !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL cmd0_err got %b%b want 00", error, timeout); end
      @(negedge clk);
      checks++; if (finished !== 1'b0) begin errors++; $display("FAIL cmd0_pulse got %b want 0", finished); end
      repeat (6) @(negedge clk);
      checks++; if (ready !== 1'b0 || sd_cmd !== 1'b1) begin errors++; $display("FAIL cmd0_gap got rdy %b cmd %b want 0 1", ready, sd_cmd); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cmd0_ready57 got %b want 1", ready); end
   endtask

   task automatic test_cmd8_ok;
      logic [47:0] f;
      int w;
      issue(6'd8, 32'h0000_01AA, RESP_48, 1'b1);
      capture_tx(f);
      checks++; if (f !== 48'h48_0000_01AA_87) begin errors++; $display("FAIL cmd8_frame got %h want 48000001aa87", f); end
      drive_reply({88'd0, 48'h08_0000_01AA_13}, 48, 5, -1);
      wait_fin(20, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL cmd8_fin_lat got %0d want 1", w); end
      checks++; if (response !== 128'h1AA) begin errors++; $display("FAIL cmd8_resp got %h want 1aa", response); end
      checks++; if (error !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL cmd8_err got %b%b want 00", error, timeout); end
      repeat (8) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cmd8_ready got %b want 1", ready); end
   endtask

   task automatic test_cmd8_errors;
      logic [47:0] f, rep;
      logic        chk, exp_err;
      logic [31:0] exp_resp;
      int          w;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin rep = 48'h08_0000_01AB_13; chk = 1'b1; exp_err = 1'b1; exp_resp = 32'h1AB; end
            1: begin rep = 48'h09_0000_01AA_13; chk = 1'b1; exp_err = 1'b1; exp_resp = 32'h1AA; end
            2: begin rep = 48'h08_0000_01AA_15; chk = 1'b0; exp_err = 1'b0; exp_resp = 32'h1AA; end
            3: begin rep = 48'h08_0000_01AA_12; chk = 1'b0; exp_err = 1'b1; exp_resp = 32'h1AA; end
            default: begin rep = 48'h48_0000_01AA_13; chk = 1'b0; exp_err = 1'b1; exp_resp = 32'h1AA; end
         endcase
         issue(6'd8, 32'h0000_01AA, RESP_48, chk);
         capture_tx(f);
         checks++; if (f !== 48'h48_0000_01AA_87) begin errors++; $display("FAIL bad%0d_frame got %h want 48000001aa87", k, f); end
         drive_reply({88'd0, rep}, 48, 3, -1);
         wait_fin(20, w);
         checks++; if (finished !== 1'b1 || error !== exp_err) begin errors++; $display("FAIL bad%0d_err got fin %b err %b want 1 %b", k, finished, error, exp_err); end
         checks++; if (response !== {96'd0, exp_resp}) begin errors++; $display("FAIL bad%0d_resp got %h want %h", k, response, exp_resp); end
         checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bad%0d_to got %b want 0", k, timeout); end
         wait_ready(20);
      end
   endtask

   task automatic test_timeout;
      logic [47:0] f;
      int w;
      issue(6'd17, 32'h0, RESP_48, 1'b1);
      capture_tx(f);
      checks++; if (f !== 48'h51_0000_0000_55) begin errors++; $display("FAIL cmd17_frame got %h want 510000000055", f); end
      wait_fin(100, w);
      checks++; if (w !== 65) begin errors++; $display("FAIL to_cycle got %0d want 65", w); end
      checks++; if (timeout !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL to_flags got %b%b want 11", timeout, error); end
      @(negedge clk);
      checks++; if (finished !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL to_hold got fin %b err %b want 0 1", finished, error); end
      repeat (6) @(negedge clk);
      checks++; if (ready !== 1'b0 || sd_cmd !== 1'b1) begin errors++; $display("FAIL to_gap got rdy %b cmd %b want 0 1", ready, sd_cmd); end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL to_ready got rdy %b to %b want 1 1", ready, timeout); end
   endtask

   task automatic test_r2;
      logic [119:0] body;
      logic [6:0]   c;
      logic [135:0] r2;
      logic [47:0]  f;
      int           w;
      body = 120'h03534453_44313647_80_12345678_00ED;
      c    = crc7_ref(body);
      r2   = {2'b00, 6'h3F, body, c, 1'b1};
      issue(6'd2, 32'h0, RESP_136, 1'b1);
      checks++; if (timeout !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL r2_clear got %b%b want 00", timeout, error); end
      capture_tx(f);
      checks++; if (f !== 48'h42_0000_0000_4D) begin errors++; $display("FAIL cmd2_frame got %h want 42000000004d", f); end
      drive_reply(r2, 136, 3, 60);
      wait_fin(20, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL r2_fin_lat got %0d want 1", w); end
      checks++; if (response !== {body, c, 1'b0}) begin errors++; $display("FAIL r2_resp got %h want %h", response, {body, c, 1'b0}); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL r2_err got %b want 0", error); end
      repeat (8) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL r2_ready got %b want 1", ready); end
      repeat (4) @(negedge clk);
      checks++; if (ready !== 1'b1 || sd_cmd !== 1'b1) begin errors++; $display("FAIL r2_noqueue got rdy %b cmd %b want 1 1", ready, sd_cmd); end
   endtask

   task automatic test_reset_mid_send;
      logic [47:0] f;
      issue(6'd8, 32'h0000_01AA, RESP_48, 1'b1);
      repeat (27) @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ready !== 1'b1 || sd_cmd !== 1'b1) begin errors++; $display("FAIL mid_idle got rdy %b cmd %b want 1 1", ready, sd_cmd); end
      checks++; if (finished !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b want 00", finished, error); end
      checks++; if (response !== 128'd0) begin errors++; $display("FAIL mid_resp got %h want 0", response); end
      issue(6'd0, 32'h0, RESP_NONE, 1'b0);
      capture_tx(f);
      checks++; if (f !== 48'h40_0000_0000_95) begin errors++; $display("FAIL mid_cmd0 got %h want 400000000095", f); end
      @(negedge clk);
      checks++; if (finished !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL mid_fin got %b%b want 10", finished, error); end
   endtask

   initial begin
      test_reset;
      test_cmd0;
      test_cmd8_ok;
      test_cmd8_errors;
      test_timeout;
      test_r2;
      test_reset_mid_send;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sd_cmd_controller.md
Name: sd_cmd_controller

Overview:
Serial engine for the SD CMD line in 1-bit SD bus mode.
- Transmits a 48-bit command frame with CRC7.
- Optionally receives a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, checks framing and CRC, then enforces the 8-clock Ncc gap.
- Sits directly upstream of the SD data controller: the block sequencer issues CMD17/CMD24 through this block and starts the data controller once `finished` pulses without error.

Parameters:
- TIMEOUT, 64, max sdClock cycles to wait for the response start bit (Ncr) before flagging timeout.
- NCC_CYCLES, 8, cycles CMD is driven high after a transaction before IDLE accepts a new start.

Ports:
- sdClock  input  1  block clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sdCmd  inout  1  SD CMD line.
- start  input  1  level; sampled only in IDLE.
- cmdIndex  input  6  command index; latched on accepted start.
- cmdArgument  input  32  argument; latched on accepted start.
- responseType  input  2  0 = none, 1 = 48-bit, 2 = 136-bit, 3 = reserved (treated as none); latched on accepted start.
- checkCrc  input  1  1 = check response CRC7 and index (0 for R3); latched on accepted start.
- ready  output  1  high in IDLE only.
- response  output  128  captured response payload.
- finished  output  1  one-cycle pulse at transaction end.
- error  output  1  valid with finished.
- timeout  output  1  valid with finished.

Behaviour:
- Reset (synchronous, active-high), takes effect on the next edge from any state, including mid-frame:
  - state -> IDLE; sdCmd driven 1.
  - response = 0; finished, error, timeout = 0; counters and CRC cleared.
- Output enable:
  - driven in IDLE, SEND and GAP;
  - released (Z) in WAIT_RESP, READ_RESP and CHECK.
  - sdCmd is combinational from state, counter and shift register, as in the data controller.
- IDLE:
  - drive 1; ready = 1.
  - On start = 1, latch the inputs and go to SEND next cycle; the start bit appears on sdCmd in the cycle after start is sampled.
- SEND: 48 cycles, MSB first.
  - Frame = {0, 1, cmdIndex, cmdArgument, crc7, 1}.
  - crc7 is polynomial x^7+x^3+1, init 0, computed serially over the first 40 bits while they are shifted out, then sent in the 7 cycles that follow.
  - After bit 0: responseType = 0 -> GAP; otherwise -> WAIT_RESP.
- WAIT_RESP:
  - The counter increments each cycle.
  - sdCmd sampled 0 -> READ_RESP; that start bit is bit N-1 of the response.
  - Counter reaches TIMEOUT first -> finished = 1, timeout = 1, error = 1, go to GAP.
- READ_RESP:
  - Shift in the remaining bits MSB first: N = 48 (47 more bits) or N = 136 (135 more bits).
  - A running CRC7 covers bits 47:8 for 48-bit responses, or bits 127:8 for 136-bit responses (the first 8 bits are excluded).
  - After the last bit -> CHECK.
- CHECK (1 cycle): error is set if any of the following holds.
  - Transmission bit (N-2) is not 0.
  - End bit is not 1.
  - checkCrc = 1 and received bits 7:1 differ from the computed CRC7.
  - checkCrc = 1, N = 48, and the received index (bits 45:40) differs from cmdIndex.
- CHECK outputs:
  - response = bits 39:8 zero-extended (48-bit), or bits 127:0 with bit 0 forced 0 (136-bit).
  - finished pulses; -> GAP.
- No-response commands: finished pulses on the cycle SEND exits, with error = 0.
- GAP: drive 1 for NCC_CYCLES cycles -> IDLE.
- response holds its value until the next CHECK or reset.
- error and timeout hold until the next accepted start.
- start outside IDLE is ignored, with no queuing.

Decomposition:
- Shared package sd_pkg holds:
  - the response type constants (RESP_NONE, RESP_48, RESP_136);
  - CMD_FRAME_LEN = 48 and RESP_LONG_LEN = 136;
  - CRC7_POLY = 7'h09;
  - the state encoding;
  - a CRC7 single-bit step function.
- One natural sub-module: sd_crc7_serial, with clear, enable and bit inputs and a 7-bit crc output.
  - It is instantiated once and reused for both TX and RX, since they never overlap.

Test Plan:
1. CMD0, arg 0x00000000, responseType 0 -> sdCmd carries 0x40_00000000_95; finished is exactly 49 cycles after start is sampled; error = 0; ready returns 8 cycles later.
2. CMD8, arg 0x000001AA, type 1, checkCrc 1 -> TX 0x48_000001AA_87. The model replies 0x08_000001AA_13 after 5 cycles -> response = 0x000001AA, error = 0, timeout = 0.
3. Same as scenario 2 with one reply argument bit flipped -> error = 1 (CRC mismatch). Separately, reply index 0x09 -> error = 1. Separately, with checkCrc = 0, a wrong CRC -> error = 0.
4. CMD17, arg 0, type 1, the model never replies -> finished = 1, timeout = 1, error = 1 exactly TIMEOUT cycles into WAIT_RESP; then 8-cycle GAP and ready = 1.
5. CMD2, type 2, the model returns a 136-bit R2 with CID 0x03534453_44313647_80_12345678_00_0ED and a valid CRC -> response[127:1] matches the CID, error = 0. Also check that start pulsed during READ_RESP is ignored.
6. Assert reset for one cycle midway through SEND (bit 20) -> next cycle state is IDLE, sdCmd = 1, finished = 0. A new CMD0 afterwards produces the correct frame.
